alu_share_arbiter: RTL

Two-port arbiter that time-shares one `eight_bit_alu` instance between two independent requesters. It sits beside the ALU in the top level and drives the ALU's operand and function inputs from registered operands. It captures the ALU result and status into a response register and returns them to the granted requester over a valid/ready handshake. Only one operation is in flight at any time.

---
 rtl/alu_share_arbiter_if.sv | 36 +++
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters and alu_share_arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int DW = 8,
  parameter int FW = 5
);
  logic          req0_valid, req0_ready;
  logic [DW-1:0] req0_a, req0_b;
  logic [FW-1:0] req0_f;
  logic          req0_cin;
  logic          req1_valid, req1_ready;
  logic [DW-1:0] req1_a, req1_b;
  logic [FW-1:0] req1_f;
  logic          req1_cin;
  logic          rsp0_valid, rsp0_ready;
  logic          rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_y;
  logic          rsp_cout;
  logic [1:0]    rsp_flag;

  modport master (
    output req0_valid, req0_a, req0_b, req0_f, req0_cin,
    output req1_valid, req1_a, req1_b, req1_f, req1_cin,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_y, rsp_cout, rsp_flag
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_f, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_f, req1_cin,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_y, rsp_cout, rsp_flag
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one eight_bit_alu between two requesters. One op in flight:
// IDLE (grant) -> EXEC (ALU evaluates registered operands) -> RESP (hold
// result until the granted requester takes it).
// Optional build macro: ALU_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration on contention; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
  parameter int DW = 8,
  parameter int FW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  output logic [FW-1:0] alu_f_o,
  output logic          alu_cin_o,
  input  logic [DW-1:0] alu_y_i,
  input  logic          alu_cout_i,
  input  logic [1:0]    alu_flag_i,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic          gnt_q;
  logic          win;
  logic          any_vld;
  logic          accept;
  logic          rsp_rdy_g;
  logic [DW-1:0] y_q;
  logic          cout_q;
  logic [1:0]    flag_q;

  assign any_vld   = bus.req0_valid | bus.req1_valid;
  assign rsp_rdy_g = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q;

  // On contention the requester that was not served last wins.
  assign win = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;

  // Pointer moves only when a response is actually consumed.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                last_q <= 1'b1;
    else if (state_q == RESP && rsp_rdy_g)     last_q <= gnt_q;
`else
  // Fixed priority: requester 0 whenever it is valid.
  assign win = ~bus.req0_valid;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  // Next state, grant and response-valid decode. Ready is qualified by
  // rst_n so nothing is granted while reset is held.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state_q)
      IDLE: if (any_vld && rst_n) begin
        accept         = 1'b1;
        bus.req0_ready = ~win;
        bus.req1_ready = win;
        state_d        = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        bus.rsp0_valid = ~gnt_q;
        bus.rsp1_valid = gnt_q;
        if (rsp_rdy_g) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly and hold between ops.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a_o   <= '0;
      alu_b_o   <= '0;
      alu_f_o   <= '0;
      alu_cin_o <= 1'b0;
      gnt_q     <= 1'b0;
    end else if (accept) begin
      alu_a_o   <= win ? bus.req1_a   : bus.req0_a;
      alu_b_o   <= win ? bus.req1_b   : bus.req0_b;
      alu_f_o   <= win ? bus.req1_f   : bus.req0_f;
      alu_cin_o <= win ? bus.req1_cin : bus.req0_cin;
      gnt_q     <= win;
    end

  // Capture ALU result at the end of EXEC; held through RESP.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      flag_q <= 2'b0;
    end else if (state_q == EXEC) begin
      y_q    <= alu_y_i;
      cout_q <= alu_cout_i;
      flag_q <= alu_flag_i;
    end

  assign bus.rsp_y    = y_q;
  assign bus.rsp_cout = cout_q;
  assign bus.rsp_flag = flag_q;
  assign busy         = (state_q != IDLE);

endmodule
